// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// Holds the FSM state encoding, the transfer timeout and the LUT index width.
package i2c_cfg_pkg;

   localparam int IDX_W         = 6;
   localparam int TIMEOUT_TICKS = 64;
   localparam int TMO_W         = 7;
   localparam int RTY_W         = 8;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD   = 4'd1,
      ST_XFER   = 4'd2,
      ST_GAP    = 4'd3,
      ST_CHECK  = 4'd4,
      ST_NEXT   = 4'd5,
      ST_DONE   = 4'd6,
      ST_FAULT  = 4'd7,
      ST_RXFER  = 4'd8,
      ST_RGAP   = 4'd9,
      ST_VERIFY = 4'd10
   } cfg_state_e;

   // Readback compares only the data byte of the word just written.
   function automatic logic rd_mismatch(input logic [7:0] rdata, input logic [23:0] word);
      return rdata != word[7:0];
   endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Sequencer <-> LUT / I2C byte engine bus.
// master: sequencer side; slave: engine and LUT side.
interface i2c_cfg_sequencer_if;
   import i2c_cfg_pkg::*;

   logic [IDX_W-1:0] oLUT_INDEX;
   logic [23:0]      iLUT_DATA;
   logic             oI2C_EN;
   logic             oI2C_CLK;
   logic [23:0]      oI2C_WDATA;
   logic             oGO;
   logic             oWR;
   logic             iEND;
   logic             iACK;
   logic [7:0]       iRDATA;

   modport master (
      output oLUT_INDEX, oI2C_EN, oI2C_CLK, oI2C_WDATA, oGO, oWR,
      input  iLUT_DATA, iEND, iACK, iRDATA
   );

   modport slave (
      input  oLUT_INDEX, oI2C_EN, oI2C_CLK, oI2C_WDATA, oGO, oWR,
      output iLUT_DATA, iEND, iACK, iRDATA
   );

endinterface

// File: rtl/i2c_cfg_sequencer_tick_gen.sv
// Free-running I2C bit-tick divider: one-cycle enable per CLK_DIV cycles and
// a 50% SCL source (low first half, high second half of each period).
module i2c_tick_gen #(
   parameter int CLK_DIV = 250
) (
   input  logic iCLK,
   input  logic iRST_N,
   output logic oI2C_EN,
   output logic oI2C_CLK
);

   localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF = 16'(CLK_DIV / 2);

   logic [15:0] div_cnt;
   logic [15:0] div_nxt;
   logic        scl;

   assign div_nxt = (div_cnt == LAST) ? 16'd0 : div_cnt + 16'd1;

   // SCL is registered from the next count so it stays glitch-free.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         div_cnt <= '0;
         scl     <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         scl     <= (div_nxt >= HALF);
      end
   end

   assign oI2C_EN  = (div_cnt == LAST);
   assign oI2C_CLK = scl;

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a LUT of {addr+W, reg, data} words and issues each to an I2C byte engine,
// with timeout and bounded retry. Define I2C_CFG_READBACK_EN to add read-back verify.
module i2c_cfg_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int CLK_DIV   = 250,
   parameter int LUT_SIZE  = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iSTART,
   i2c_cfg_sequencer_if.master bus,
   output logic                oBUSY,
   output logic                oDONE,
   output logic                oERR,
   output logic [IDX_W-1:0]    oERR_INDEX
);

   localparam logic [3:0] S_IDLE   = 4'(ST_IDLE);
   localparam logic [3:0] S_LOAD   = 4'(ST_LOAD);
   localparam logic [3:0] S_XFER   = 4'(ST_XFER);
   localparam logic [3:0] S_GAP    = 4'(ST_GAP);
   localparam logic [3:0] S_CHECK  = 4'(ST_CHECK);
   localparam logic [3:0] S_NEXT   = 4'(ST_NEXT);
   localparam logic [3:0] S_DONE   = 4'(ST_DONE);
   localparam logic [3:0] S_FAULT  = 4'(ST_FAULT);
`ifdef I2C_CFG_READBACK_EN
   localparam logic [3:0] S_RXFER  = 4'(ST_RXFER);
   localparam logic [3:0] S_RGAP   = 4'(ST_RGAP);
   localparam logic [3:0] S_VERIFY = 4'(ST_VERIFY);
`endif

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

   logic [3:0]       state;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry;
   logic [TMO_W-1:0] tmo_cnt;
   logic             fail;
   logic             tick_seen;
   logic [23:0]      wdata;
   logic             wr;
   logic             done;
   logic             err;
   logic [IDX_W-1:0] err_idx;

   logic             tick;
   logic             scl;
   logic             tmo_hit;
   logic             can_retry;
   logic             gap_ok;
   logic [3:0]       fail_state;

   i2c_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .oI2C_EN  (tick),
      .oI2C_CLK (scl)
   );

   assign tmo_hit    = tick && (tmo_cnt == TMO_LAST);
   assign can_retry  = retry < RTY_MAX;
   assign fail_state = can_retry ? S_LOAD : S_FAULT;
   // Leave the gap only once the engine has dropped END and a bit time has passed.
   assign gap_ok     = (tick || tick_seen) && !bus.iEND;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= S_IDLE;
         idx       <= '0;
         retry     <= '0;
         tmo_cnt   <= '0;
         fail      <= 1'b0;
         tick_seen <= 1'b0;
         wdata     <= '0;
         wr        <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         err_idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iSTART) begin
                  idx     <= '0;
                  retry   <= '0;
                  done    <= 1'b0;
                  err     <= 1'b0;
                  err_idx <= '0;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               wdata   <= bus.iLUT_DATA;
               wr      <= 1'b1;
               tmo_cnt <= '0;
               state   <= S_XFER;
            end
            S_XFER: begin
               if (bus.iEND) begin
                  fail      <= bus.iACK;
                  tick_seen <= 1'b0;
                  state     <= S_GAP;
               end else if (tmo_hit) begin
                  fail      <= 1'b1;
                  tick_seen <= 1'b0;
                  state     <= S_GAP;
               end else if (tick) begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_GAP: begin
               if (tick) tick_seen <= 1'b1;
               if (gap_ok) state <= S_CHECK;
            end
            S_CHECK: begin
               if (!fail) begin
`ifdef I2C_CFG_READBACK_EN
                  wr      <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= S_RXFER;
`else
                  state   <= S_NEXT;
`endif
               end else begin
                  if (can_retry) retry <= retry + RTY_W'(1);
                  state <= fail_state;
               end
            end
`ifdef I2C_CFG_READBACK_EN
            S_RXFER: begin
               if (bus.iEND) begin
                  fail      <= bus.iACK | rd_mismatch(bus.iRDATA, wdata);
                  tick_seen <= 1'b0;
                  state     <= S_RGAP;
               end else if (tmo_hit) begin
                  fail      <= 1'b1;
                  tick_seen <= 1'b0;
                  state     <= S_RGAP;
               end else if (tick) begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_RGAP: begin
               if (tick) tick_seen <= 1'b1;
               if (gap_ok) state <= S_VERIFY;
            end
            S_VERIFY: begin
               if (!fail) begin
                  state <= S_NEXT;
               end else begin
                  if (can_retry) retry <= retry + RTY_W'(1);
                  state <= fail_state;
               end
            end
`endif
            S_NEXT: begin
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  retry <= '0;
                  state <= S_LOAD;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            S_FAULT: begin
               err     <= 1'b1;
               err_idx <= idx;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef I2C_CFG_READBACK_EN
   assign bus.oGO = (state == S_XFER) || (state == S_RXFER);
`else
   assign bus.oGO = (state == S_XFER);
   logic unused_rdata;
   assign unused_rdata = ^bus.iRDATA;
`endif

   assign bus.oLUT_INDEX = idx;
   assign bus.oI2C_EN    = tick;
   assign bus.oI2C_CLK   = scl;
   assign bus.oI2C_WDATA = wdata;
   assign bus.oWR        = wr;

   assign oBUSY      = (state != S_IDLE);
   assign oDONE      = done;
   assign oERR       = err;
   assign oERR_INDEX = err_idx;

endmodule
